alarm_sensor_pio: RTL
=====================

# alarm_sensor_pio

Avalon-MM slave input port with per-bit debounce, edge capture and a maskable interrupt, for the alarm's door/PIR/button sensor lines. It is the input-direction companion of the buzzer output PIO. It sits on the CPU1 data master like the other PIOs, and its `irq` drives one Nios II interrupt line. Software reads debounced levels, arms per-bit interrupts and clears captured edges.

## Interface
Parameters:
- `WIDTH`, 4: number of sensor inputs (1..32).
- `DEBOUNCE_W`, 16: width of the debounce period register and of each per-bit counter.
- `DEBOUNCE_DEFAULT`, 16'd50000: reset value of the period register (1 ms at 50 MHz).
- `EDGE_TYPE`, 0: edge that sets capture bits. 0 = rising, 1 = falling, 2 = any.

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data; combinational from `address` and registers, zero wait states.
- `in_port`  in  WIDTH  raw asynchronous sensor inputs.
- `irq`  out  1  level interrupt, active-high.

## Operation
- A write occurs when `chipselect && !write_n`.
- Register map (unused bits read 0):
  - Address 0 DATA (RO): debounced levels `deb[WIDTH-1:0]`. Writes are ignored.
  - Address 1 PERIOD (RW): `per[DEBOUNCE_W-1:0]`. A write takes `writedata[DEBOUNCE_W-1:0]`.
  - Address 2 IRQMASK (RW): `mask[WIDTH-1:0]`.
  - Address 3 EDGECAP (R/W1C): `cap[WIDTH-1:0]`. Writing 1 to a bit clears it; writing 0 leaves it.
- Synchronizer: each `in_port` bit passes through two flops (`s1`, then `s2`). Only `s2` is used downstream.
- Debounce runs per bit i on every clock edge:
  - If `s2[i] == deb[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == per`: `deb[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i] + 1`.
  - A level is therefore accepted after `per+1` consecutive mismatching cycles. `per = 0` gives a single-cycle accept.
  - Any return to a match before acceptance discards the partial count (glitch rejection).
- A PERIOD write mid-count takes effect from the next cycle's comparison. A count already above the new `per` keeps incrementing until it wraps or the input matches. Software writes PERIOD only while idle.
- Edge capture:
  - `cap[i]` sets on the same edge at which `deb[i]` updates, when the transition matches `EDGE_TYPE`.
  - If an EDGECAP write clears a bit on the same cycle it would set, the set wins.
- `irq = |(cap & mask)`, combinational from registers. It stays high until software clears the captured bits or masks them.
- `readdata`: the selected register, zero-extended to 32 bits. Reads have no side effects.

## Timing
- Reset (async assert, released synchronously by the system reset controller):
  - `s1`, `s2`, `deb`, `cnt`, `mask`, `cap` = 0.
  - `per` = `DEBOUNCE_DEFAULT`.
  - `irq` = 0; `readdata` = 0 for addresses 0, 2 and 3.
- Reset asserted mid-count aborts the count. Inputs held high through reset are accepted `per+3` edges after release, and set `cap` if `EDGE_TYPE` is 0 or 2.
- Latency from a stable `in_port` change (first sampling edge = edge 1) to visible `deb`/`cap`: end of edge `per+3`. `irq` rises in the same cycle if the bit is masked in.
- Register writes are visible on `readdata` the cycle after the write edge.
- Clearing `cap` by a write drops `irq` after that edge. No pending bit is lost, except a bit that re-sets on the same edge, which keeps `irq` high.

## Test plan
- Reset values: read all 4 addresses after reset -> 0x0, 0xC350, 0x0, 0x0; `irq` = 0.
- Debounce accept: write PERIOD = 3 and IRQMASK = 0x1, then raise `in_port[0]` and hold. DATA and EDGECAP read 0x1 from edge 6 onward (not before); `irq` = 1 from edge 6.
- Glitch rejection: with PERIOD = 3, pulse `in_port[1]` high for 2 cycles -> DATA, EDGECAP and `irq` stay 0. A 4-cycle pulse with PERIOD = 2 is accepted, then released, giving DATA back to 0 with `cap[1]` = 1 (EDGE_TYPE = 0).
- W1C and mask:
  - With `cap` = 0x5 and mask = 0x4, `irq` = 1.
  - Write EDGECAP = 0x4 -> `cap` = 0x1 and `irq` = 0.
  - Then write mask = 0x1 -> `irq` = 1.
- Set/clear collision: write EDGECAP = 0x1 on the exact edge `deb[0]` rises -> `cap[0]` stays 1 and `irq` stays 1.
- Async reset mid-count: assert `reset_n` = 0 at count 2 of 3 -> all outputs 0 immediately. After release with the input still high, acceptance occurs at edge `DEBOUNCE_DEFAULT`+3.

Source files
------------

// File: rtl/alarm_sensor_pio.sv
// alarm_sensor_pio: Avalon-MM input PIO for door/PIR/button sensor lines.
// Two-flop synchronizer, per-bit debounce, edge capture (W1C) and a
// maskable level interrupt.

// One sensor bit: debounce counter, debounced level and capture strobe.
module alarm_sensor_lane #(
  parameter int DEBOUNCE_W = 16,
  parameter int EDGE_TYPE  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  din,
  input  logic [DEBOUNCE_W-1:0] per,
  output logic                  deb,
  output logic                  cap_set
);
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
  logic                  deb_q, deb_d;
  logic                  accept;

  // Count consecutive mismatches; accept after per+1, drop count on any match.
  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    accept = 1'b0;
    if (din == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == per) begin
      deb_d  = din;
      cnt_d  = '0;
      accept = 1'b1;
    end else begin
      cnt_d = cnt_q + DEBOUNCE_W'(1);
    end
  end

  // Capture strobe fires on the same edge the debounced level flips.
  always_comb begin
    cap_set = accept && ((EDGE_TYPE == 2) ||
                         (EDGE_TYPE == 0 && din) ||
                         (EDGE_TYPE == 1 && !din));
  end

  // Counter and debounced level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;
endmodule

module alarm_sensor_pio #(
  parameter int                    WIDTH            = 4,
  parameter int                    DEBOUNCE_W       = 16,
  parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_DEFAULT = 16'd50000,
  parameter int                    EDGE_TYPE        = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0]      s1_q, s2_q;
  logic [WIDTH-1:0]      deb, cap_set, clr;
  logic [WIDTH-1:0]      mask_q, mask_d, cap_q, cap_d;
  logic [DEBOUNCE_W-1:0] per_q, per_d;
  logic                  wr;
  logic                  unused_wdata;

  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  // Per-bit debounce lanes, all sharing the one period register.
  alarm_sensor_lane #(
    .DEBOUNCE_W (DEBOUNCE_W),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_lane [WIDTH-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (s2_q),
    .per     (per_q),
    .deb     (deb),
    .cap_set (cap_set)
  );

  // Register writes; a capture set beats a same-cycle W1C clear.
  always_comb begin
    per_d  = per_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr) begin
      case (address)
        2'd1:    per_d  = writedata[DEBOUNCE_W-1:0];
        2'd2:    mask_d = writedata[WIDTH-1:0];
        2'd3:    clr    = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    cap_d = (cap_q & ~clr) | cap_set;
  end

  // Zero-wait-state read mux, zero-extended.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0]      = deb;
      2'd1:    readdata[DEBOUNCE_W-1:0] = per_q;
      2'd2:    readdata[WIDTH-1:0]      = mask_q;
      default: readdata[WIDTH-1:0]      = cap_q;
    endcase
  end

  // Synchronizer and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      per_q  <= DEBOUNCE_DEFAULT;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      s1_q   <= in_port;
      s2_q   <= s1_q;
      per_q  <= per_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  assign irq = |(cap_q & mask_q);
endmodule
